// File: rtl/led_status_ctrl.sv
// Two-channel RGB status LED driver: a status change flashes the new colour, then holds it steady.
// Define LED_STATUS_PWM_EN to dim the steady colour with a shared 16-step PWM.
module led_status_ctrl #(
  parameter int unsigned FLASH_CYC   = 5_000_000,
  parameter int unsigned FLASH_COUNT = 3,
  parameter int unsigned PWM_DUTY    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game1_state,
  input  logic [1:0] game2_state,
  input  logic       mute,
  output logic [2:0] led16,
  output logic [2:0] led17
);

  localparam int unsigned PW = $clog2(FLASH_CYC);
  localparam int unsigned BW = $clog2(FLASH_COUNT) + 1;
  localparam logic [PW-1:0] PhaseLast = PW'(FLASH_CYC - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(FLASH_COUNT - 1);

  if (FLASH_CYC < 2 || FLASH_COUNT < 1 || PWM_DUTY < 1 || PWM_DUTY > 16) begin : g_bad_param
    $error("led_status_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {StSteady, StFlashOn, StFlashOff} state_e;

  function automatic logic [2:0] color(input logic [1:0] s);
    case (s)
      2'b00:   color = 3'b001;
      2'b01:   color = 3'b010;
      2'b10:   color = 3'b100;
      default: color = 3'b101;
    endcase
  endfunction

  logic steady_lit;

`ifdef LED_STATUS_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign steady_lit = ({1'b0, pwm_cnt} < 5'(PWM_DUTY));
`else
  assign steady_lit = 1'b1;
`endif

  logic [1:0] state_in [2];
  logic [2:0] led_out  [2];

  assign state_in[0] = game1_state;
  assign state_in[1] = game2_state;
  assign led16       = led_out[0];
  assign led17       = led_out[1];

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [1:0]    s_q, s_prev;
    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [2:0]    led_q, led_d;
    logic          change;

    assign change     = (s_q != s_prev);
    assign led_out[c] = led_q;

    always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      blink_d = blink_q;
      if (change) begin
        state_d = StFlashOn;
        phase_d = '0;
        blink_d = '0;
      end else begin
        unique case (state_q)
          StFlashOn: begin
            if (phase_q == PhaseLast) begin
              state_d = StFlashOff;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
          StFlashOff: begin
            if (phase_q == PhaseLast) begin
              phase_d = '0;
              if (blink_q == BlinkLast) begin
                state_d = StSteady;
              end else begin
                state_d = StFlashOn;
                blink_d = blink_q + 1'b1;
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Output follows the next state so a change shows on the LED one edge after sampling.
      if (mute || state_d == StFlashOff)          led_d = 3'b000;
      else if (state_d == StSteady && !steady_lit) led_d = 3'b000;
      else                                         led_d = color(s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q     <= 2'b00;
        s_prev  <= 2'b00;
        state_q <= StSteady;
        phase_q <= '0;
        blink_q <= '0;
        led_q   <= 3'b000;
      end else begin
        s_q     <= state_in[c];
        s_prev  <= s_q;
        state_q <= state_d;
        phase_q <= phase_d;
        blink_q <= blink_d;
        led_q   <= led_d;
      end
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: constant vector table, hand-written corner sequences and random
// stimulus checked against a timeline model of the flash behaviour.
module tb_led_status_ctrl;

  localparam int FC   = 4;
  localparam int CNT  = 2;
  localparam int DUTY = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] g1 = 2'b00;
  logic [1:0] g2 = 2'b00;
  logic       mute = 1'b0;
  logic [2:0] led16, led17;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .FLASH_CYC  (FC),
    .FLASH_COUNT(CNT),
    .PWM_DUTY   (DUTY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game1_state(g1),
    .game2_state(g2),
    .mute       (mute),
    .led16      (led16),
    .led17      (led17)
  );

  typedef struct {
    logic [1:0] g1;
    logic [1:0] g2;
    logic       mute;
    int         n;
    logic [2:0] e16;
    logic [2:0] e17;
  } vec_t;

  vec_t tbl[$];

  // Model: edge counter, last sampled value and the edge at which it last changed.
  logic [2:0] cmap [4] = '{3'b001, 3'b010, 3'b100, 3'b101};
  int         n;
  int         lc [2];
  logic [1:0] sv [2];
  logic [2:0] exp_led [2];

  function automatic logic [2:0] model_led(int c, int en);
    int el;
    el = en - lc[c] - 1;
    if (mute) return 3'b000;
    if (el >= 0 && el < 2 * FC * CNT) begin
      if ((el / FC) % 2 == 1) return 3'b000;
      return cmap[sv[c]];
    end
`ifdef LED_STATUS_PWM_EN
    if (((en - 1) % 16) >= DUTY) return 3'b000;
`endif
    return cmap[sv[c]];
  endfunction

  task automatic model_reset();
    n     = 0;
    lc[0] = -1000;
    lc[1] = -1000;
    sv[0] = 2'b00;
    sv[1] = 2'b00;
  endtask

  task automatic step();
    n++;
    exp_led[0] = model_led(0, n);
    exp_led[1] = model_led(1, n);
    @(posedge clk);
    #1;
    if (g1 != sv[0]) begin lc[0] = n; sv[0] = g1; end
    if (g2 != sv[1]) begin lc[1] = n; sv[1] = g2; end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_chk(input string name);
    step();
    check({name, " led16"}, led16, exp_led[0]);
    check({name, " led17"}, led17, exp_led[1]);
  endtask

  initial begin
    tbl.push_back('{2'b00, 2'b00, 1'b0, 3, 3'b001, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 1, 3'b001, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 4, 3'b010, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 4, 3'b000, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 4, 3'b010, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 4, 3'b000, 3'b001});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 3, 3'b010, 3'b001});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 1, 3'b010, 3'b001});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 4, 3'b101, 3'b100});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 4, 3'b000, 3'b000});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 4, 3'b101, 3'b100});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 4, 3'b000, 3'b000});
    tbl.push_back('{2'b11, 2'b10, 1'b0, 3, 3'b101, 3'b100});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 1, 3'b101, 3'b100});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 2, 3'b001, 3'b010});
    tbl.push_back('{2'b00, 2'b01, 1'b1, 8, 3'b000, 3'b000});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 2, 3'b001, 3'b010});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 4, 3'b000, 3'b000});
    tbl.push_back('{2'b00, 2'b01, 1'b0, 3, 3'b001, 3'b010});

    // Reset with both inputs idle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset led16", led16, 3'b000);
    check("reset led17", led17, 3'b000);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      g1   = tbl[i].g1;
      g2   = tbl[i].g2;
      mute = tbl[i].mute;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
`ifndef LED_STATUS_PWM_EN
        check($sformatf("tbl%0d.%0d led16", i, k), led16, tbl[i].e16);
        check($sformatf("tbl%0d.%0d led17", i, k), led17, tbl[i].e17);
`else
        check($sformatf("tbl%0d.%0d led16", i, k), led16, exp_led[0]);
        check($sformatf("tbl%0d.%0d led17", i, k), led17, exp_led[1]);
`endif
      end
    end

    // Restart: a second change six edges into a flash starts a fresh full flash.
    g1 = 2'b01;
    for (int k = 0; k < 6; k++) step_chk("restart pre");
    g1 = 2'b10;
    step();
    check("restart old off", led16, 3'b000);
    step();
    check("restart first on", led16, 3'b100);
    for (int k = 0; k < 19; k++) step_chk("restart");

    // Reset asserted mid-flash clears the LEDs without waiting for a clock edge.
    g2 = 2'b10;
    for (int k = 0; k < 3; k++) step_chk("pre abort");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort led16", led16, 3'b000);
    check("abort led17", led17, 3'b000);
    @(posedge clk);
    #1;
    check("abort hold led17", led17, 3'b000);
    g1 = 2'b01;
    g2 = 2'b00;
    rst_n = 1'b1;
    model_reset();
    step();
    check("release first led16", led16, 3'b001);
    check("release first led17", led17, 3'b001);
    step();
    check("release flash led16", led16, 3'b010);
    check("release flash led17", led17, 3'b001);
    for (int k = 0; k < 18; k++) step_chk("release");

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) g1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) g2 = 2'($urandom_range(0, 3));
      mute = ($urandom_range(0, 7) == 0);
      step_chk("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
